// File: rtl/poly_pkg.sv
// Shared definitions for the sequential polynomial multiplier.
// Holds default sizing, the mode encoding and the FSM state encoding.
// No ports; imported by poly_mul_seq and poly_mac_lane.
package poly_pkg;

   localparam int DEF_N = 4;   // coefficient count (power of two, >= 2)
   localparam int DEF_W = 4;   // coefficient width, arithmetic is mod 2^W

   localparam logic MODE_NEGACYCLIC = 1'b0;   // reduce mod x^N + 1
   localparam logic MODE_CYCLIC     = 1'b1;   // reduce mod x^N - 1

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/poly_mac_lane.sv
// One accumulator coefficient of the polynomial product: multiply, optional
// negate, accumulate, register. Latency: one cycle per accumulate step.
// Ports: clk/reset, clr_i (zero the sum), en_i (add a term), neg_i, a_i, b_i, acc_o.
module poly_mac_lane
   import poly_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic         neg_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] acc_o
);

   logic [W-1:0] prod_lo;
   logic [W-1:0] term;
   logic [W-1:0] acc_q;
   logic [W-1:0] acc_d;

   // Only the low W bits of the 2W-bit product survive the mod 2^W
   // reduction, so the product is sized to W bits directly.
   always_comb begin
      prod_lo = a_i * b_i;
      term    = neg_i ? (~prod_lo + 1'b1) : prod_lo;
      acc_d   = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q + term;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/poly_mul_seq.sv
// Sequential cyclic / negacyclic polynomial multiplier (N coefficients of W bits).
// One job: accept, N accumulate cycles, one write-back edge into DONE (out_valid
// on the (N+1)th edge after accept). Result held until out_valid & out_ready.
// Ports: clk, reset, in_valid/in_ready, mode, a_flat, b_flat,
//        out_valid/out_ready, w_flat (coefficient i at bits [i*W +: W]).
module poly_mul_seq
   import poly_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int W = DEF_W
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           mode,
   input  logic [N*W-1:0] a_flat,
   input  logic [N*W-1:0] b_flat,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*W-1:0] w_flat
);

   localparam int LW = $clog2(N);
   localparam int IW = LW + 1;     // idx must reach N to mark the end of BUSY

   state_e                 state_q;
   logic [IW-1:0]          idx_q;
   logic [N-1:0][W-1:0]    a_q;
   logic [N-1:0][W-1:0]    b_q;
   logic                   mode_q;
   logic                   out_valid_q;
   logic [N-1:0][W-1:0]    w_q;
   logic [N-1:0][W-1:0]    acc;

   logic                   accept;
   logic                   mac_en;
   logic [LW-1:0]          idx_lo;
   logic [W-1:0]           a_sel;

   assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
   assign accept   = in_valid & in_ready;

   // The top idx bit is clear exactly while idx < N.
   assign mac_en   = (state_q == ST_BUSY) & ~idx_q[LW];
   assign idx_lo   = idx_q[LW-1:0];
   assign a_sel    = a_q[idx_lo];

   // Lane j adds a_idx * b_k with k = (j - idx) mod N. The pair wrapped past
   // x^N exactly when idx > j, and that term is negated in negacyclic mode.
   for (genvar j = 0; j < N; j++) begin : g_lane
      logic [LW-1:0] k_sel;
      logic          neg;

      assign k_sel = LW'(j) - idx_lo;
      assign neg   = (mode_q == MODE_NEGACYCLIC) & (idx_lo > LW'(j));

      poly_mac_lane #(.W(W)) u_lane (
         .clk   (clk),
         .reset (reset),
         .clr_i (accept),
         .en_i  (mac_en),
         .neg_i (neg),
         .a_i   (a_sel),
         .b_i   (b_q[k_sel]),
         .acc_o (acc[j])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         mode_q      <= MODE_NEGACYCLIC;
         out_valid_q <= 1'b0;
         w_q         <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               // Handoff without a new job returns to IDLE; a simultaneous
               // accept below overrides that and starts the next job directly.
               if ((state_q == ST_DONE) && out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
               if (accept) begin
                  a_q     <= a_flat;
                  b_q     <= b_flat;
                  mode_q  <= mode;
                  idx_q   <= '0;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (mac_en) begin
                  idx_q <= idx_q + 1'b1;
               end else begin
                  // Lane registers hold the final sums; publish them.
                  w_q         <= acc;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign w_flat    = w_q;

endmodule

// File: tb/tb_poly_mul_seq.sv
module tb_poly_mul_seq;

   localparam int N = 4;
   localparam int W = 4;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic          mode;
   logic [15:0]   a_flat;
   logic [15:0]   b_flat;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   w_flat;

   int n_pass  = 0;
   int n_total = 0;

   poly_mul_seq #(.N(N), .W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .a_flat    (a_flat),
      .b_flat    (b_flat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .w_flat    (w_flat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        m;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] w;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Straight convolution with wrap-around sign, independent of the rotation scheme.
   function automatic logic [15:0] ref_mul(input logic m, input logic [15:0] a, input logic [15:0] b);
      logic [3:0] w [4];
      logic [7:0] p;
      for (int j = 0; j < 4; j++) w[j] = '0;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 4; k++) begin
            p = {4'h0, a[i*4 +: 4]} * {4'h0, b[k*4 +: 4]};
            if ((i + k >= 4) && (m == 1'b0)) w[(i+k)%4] = w[(i+k)%4] - p[3:0];
            else                             w[(i+k)%4] = w[(i+k)%4] + p[3:0];
         end
      end
      return {w[3], w[2], w[1], w[0]};
   endfunction

   task automatic start_job(input logic m, input logic [15:0] a, input logic [15:0] b);
      int t = 0;
      while (!in_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      chk("ready_before_accept", {31'b0, in_ready}, 32'd1);
      mode = m; a_flat = a; b_flat = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      // operands need not stay stable after the accept edge
      a_flat = 16'($urandom); b_flat = 16'($urandom); mode = ~m;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      int bad;
      logic [15:0] ra, rb;
      logic        rm;

      vt[0]  = '{"nega_1px_x3",   1'b0, 16'h0011, 16'h1000, 16'h100F};
      vt[1]  = '{"cyc_1px_x3",    1'b1, 16'h0011, 16'h1000, 16'h1001};
      vt[2]  = '{"ovf_15x15",     1'b0, 16'h000F, 16'h000F, 16'h0001};
      vt[3]  = '{"ovf_3x5",       1'b0, 16'h0003, 16'h0005, 16'h000F};
      vt[4]  = '{"nega_x_x3",     1'b0, 16'h0010, 16'h1000, 16'h000F};
      vt[5]  = '{"cyc_x_x3",      1'b1, 16'h0010, 16'h1000, 16'h0001};
      vt[6]  = '{"ident",         1'b0, 16'h4321, 16'h0001, 16'h4321};
      vt[7]  = '{"cyc_ones",      1'b1, 16'h1111, 16'h1111, 16'h4444};
      vt[8]  = '{"nega_ones",     1'b0, 16'h1111, 16'h1111, 16'h420E};
      vt[9]  = '{"nega_2x2_3x3",  1'b0, 16'h0200, 16'h3000, 16'h00A0};
      vt[10] = '{"cyc_2x2_3x3",   1'b1, 16'h0200, 16'h3000, 16'h0060};
      vt[11] = '{"ovf_cyc_15x15", 1'b1, 16'h000F, 16'h000F, 16'h0001};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      mode = 1'b0; a_flat = '0; b_flat = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_w_flat",    {16'b0, w_flat},    32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

      // Directed table
      for (int v = 0; v < 12; v++) begin
         start_job(vt[v].m, vt[v].a, vt[v].b);
         chk({vt[v].name, "_busy_ready"}, {31'b0, in_ready}, 32'd0);
         wait_done(lat);
         chk({vt[v].name, "_latency"}, lat, 32'd5);
         chk({vt[v].name, "_w"}, {16'b0, w_flat}, {16'b0, vt[v].w});
         release_result();
         chk({vt[v].name, "_drop_valid"}, {31'b0, out_valid}, 32'd0);
         chk({vt[v].name, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
         chk({vt[v].name, "_w_held"}, {16'b0, w_flat}, {16'b0, vt[v].w});
      end

      // Backpressure, then handoff with a new job on the same edge
      start_job(1'b0, 16'h4321, 16'h0010);
      wait_done(lat);
      chk("bp_latency", lat, 32'd5);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid !== 1'b1 || w_flat !== 16'h321C || in_ready !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      chk("bp_stall_stable", bad, 32'd0);
      chk("bp_w", {16'b0, w_flat}, 32'h321C);
      out_ready = 1'b1; in_valid = 1'b1; mode = 1'b1; a_flat = 16'h1111; b_flat = 16'h1111;
      #1;
      chk("bp_handoff_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0; a_flat = '0; b_flat = '0;
      chk("bp_handoff_valid_drop", {31'b0, out_valid}, 32'd0);
      chk("bp_handoff_busy",       {31'b0, in_ready},  32'd0);
      chk("bp_handoff_w_held",     {16'b0, w_flat},    32'h321C);
      wait_done(lat);
      chk("bp_second_latency", lat, 32'd5);
      chk("bp_second_w", {16'b0, w_flat}, 32'h4444);
      release_result();

      // Reset two cycles into BUSY
      start_job(1'b0, 16'h0011, 16'h1000);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_busy_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_busy_w_flat",    {16'b0, w_flat},    32'd0);
      #2;
      reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
      end
      chk("rst_no_stale_valid", bad, 32'd0);
      start_job(1'b1, 16'h0200, 16'h3000);
      wait_done(lat);
      chk("rst_next_latency", lat, 32'd5);
      chk("rst_next_w", {16'b0, w_flat}, 32'h0060);
      release_result();

      // Random operands in both modes with random result stalls
      for (int r = 0; r < 2000; r++) begin
         rm = r[0];
         ra = 16'($urandom);
         rb = 16'($urandom);
         start_job(rm, ra, rb);
         wait_done(lat);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         chk("rand_w", {15'b0, out_valid, w_flat}, {15'b0, 1'b1, ref_mul(rm, ra, rb)});
         release_result();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/poly_mul_seq.md
POLY_MUL_SEQ -- requirements
Module: poly_mul_seq

Interface
REQ-001 Parameter N, default 4: polynomial length (coefficient count), power of two, N >= 2.
REQ-002 Parameter W, default 4: coefficient width in bits; all arithmetic is modulo 2^W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair and mode are valid.
REQ-006 in_ready  output  1  block can accept operands this cycle.
REQ-007 mode  input  1  0 = negacyclic (mod x^N+1), 1 = cyclic (mod x^N-1); sampled with operands.
REQ-008 a_flat  input  N*W  operand A; coefficient i at bits [i*W+W-1 : i*W].
REQ-009 b_flat  input  N*W  operand B; same packing.
REQ-010 out_valid  output  1  w_flat holds a finished product.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 w_flat  output  N*W  product coefficients; same packing.

Function
REQ-013 Compute w_j = sum over i+k ≡ j (mod N) of s * a_i * b_k, mod 2^W, for j = 0..N-1; s = -1 if i+k >= N and mode = 0, otherwise s = +1.
REQ-014 FSM states: IDLE, BUSY, DONE.
REQ-015 Accept occurs on a rising edge with in_valid & in_ready; A, B and mode are latched, the accumulator is cleared, idx is set to 0, and the FSM goes to BUSY.
REQ-016 BUSY behaviour, per cycle: for all j, acc_j += a_idx * (b rotated by idx, wrapped terms negated when mode = 0), truncated to W bits; idx increments.
REQ-017 BUSY runs exactly N cycles, then the FSM goes to DONE; out_valid is first high on the (N+1)th rising edge after the accept edge.
REQ-018 In DONE, out_valid = 1 and w_flat is held stable until out_valid & out_ready.
REQ-019 in_ready = (state == IDLE) | (state == DONE & out_ready), combinational.
REQ-020 Result handoff with in_valid high on the same edge: a new accept occurs, with no idle bubble between jobs.
REQ-021 Result handoff without a new operand: the FSM goes to IDLE and out_valid drops.
REQ-022 in_valid in BUSY is ignored (in_ready = 0); the input bus is not required to be stable outside the accept edge.
REQ-023 Products a_i*b_k are formed at 2W bits and truncated; negation is two's complement modulo 2^W.
REQ-024 w_flat changes only on the transition into DONE.

Reset
REQ-025 Reset assertion forces IDLE, idx = 0, accumulator = 0, w_flat = 0 and out_valid = 0 immediately, independent of clk.
REQ-026 Reset mid-BUSY or mid-DONE discards the job; no partial result is ever flagged valid.
REQ-027 After reset deasserts, in_ready = 1 on the next cycle.

Structure
REQ-028 Shared package poly_pkg holds the FSM state encodings, the default N and W, and the mode encoding constants.
REQ-029 One sub-module, poly_mac_lane, implements one accumulator coefficient: multiply, conditional negate, add and register. It is instantiated N times via generate.
REQ-030 The top level holds the FSM, idx counter, operand registers and rotation/sign selection.

Verification (N=4, W=4)
REQ-031 Negacyclic test: a = 1+x, b = x^3, mode = 0 -> w = {w0=15, w1=0, w2=0, w3=1}, with out_valid 5 edges after accept.
REQ-032 Cyclic test: same operands with mode = 1 -> w = {1, 0, 0, 1}.
REQ-033 Overflow test: a0 = 15, b0 = 15, others 0 -> w0 = 1, rest 0; a0 = 3, b0 = 5 -> w0 = 15.
REQ-034 Backpressure test: hold out_ready = 0 for 10 cycles -> out_valid and w_flat stay stable and in_ready = 0. Then raise out_ready together with a new in_valid -> accept on the same edge, and the second result is correct.
REQ-035 Reset test: assert reset 2 cycles into BUSY -> out_valid = 0 and w_flat = 0 at once; the next job computes correctly.
REQ-036 Random test: 1000 random operands in each mode with random out_ready stalls, checked against a software reference model.
